// File: rtl/axilite_uart_console_master.sv
// AXI4-Lite initiator that drives a UART Lite register map and bridges its FIFOs to byte streams.
// Optional macro UART_CONSOLE_IRQ_EN: interrupt-driven polling and CTRL=0x13 at init.
module axilite_uart_console_master #(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned POLL_INTERVAL = 16
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  output logic [31:0] m_axilite_awaddr,
  output logic [2:0]  m_axilite_awprot,
  output logic        m_axilite_awvalid,
  input  logic        m_axilite_awready,
  output logic [31:0] m_axilite_wdata,
  output logic [3:0]  m_axilite_wstrb,
  output logic        m_axilite_wvalid,
  input  logic        m_axilite_wready,
  input  logic [1:0]  m_axilite_bresp,
  input  logic        m_axilite_bvalid,
  output logic        m_axilite_bready,
  output logic [31:0] m_axilite_araddr,
  output logic [2:0]  m_axilite_arprot,
  output logic        m_axilite_arvalid,
  input  logic        m_axilite_arready,
  input  logic [31:0] m_axilite_rdata,
  input  logic [1:0]  m_axilite_rresp,
  input  logic        m_axilite_rvalid,
  output logic        m_axilite_rready,
  input  logic [7:0]  tx_data_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  output logic [7:0]  rx_data_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  input  logic        int_i,
  output logic        err_o,
  output logic [7:0]  dbg_o
);

  // Handshakes: a transfer happens on a rising clock edge where valid and ready are both 1;
  // valid, once raised, holds with stable payload until that edge; ready may change freely.

  typedef enum logic [3:0] {
    ST_INIT    = 4'd0,
    ST_INIT_B  = 4'd1,
    ST_IDLE    = 4'd2,
    ST_STAT_AR = 4'd3,
    ST_STAT_R  = 4'd4,
    ST_RX_AR   = 4'd5,
    ST_RX_R    = 4'd6,
    ST_TX_AW   = 4'd7,
    ST_TX_B    = 4'd8
  } state_e;

  localparam logic [31:0] RX_OFF   = 32'h0;
  localparam logic [31:0] TX_OFF   = 32'h4;
  localparam logic [31:0] STAT_OFF = 32'h8;
  localparam logic [31:0] CTRL_OFF = 32'hC;
`ifdef UART_CONSOLE_IRQ_EN
  localparam logic [31:0] CTRL_INIT = 32'h13;
`else
  localparam logic [31:0] CTRL_INIT = 32'h03;
`endif
  localparam logic [15:0] POLL_LAST = 16'(POLL_INTERVAL - 1);

  state_e      state_q, state_d;
  logic [31:0] awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic        arvalid_q, arvalid_d, rready_q, rready_d, req_sent_q, req_sent_d;
  logic        tx_full_q, tx_full_d, rx_full_q, rx_full_d, err_q, err_d;
  logic [7:0]  tx_byte_q, tx_byte_d, rx_data_q, rx_data_d;
  logic        rx_avail_q, rx_avail_d, tx_fifo_full_q, tx_fifo_full_d;
  logic        last_rx_q, last_rx_d, init_done_q, init_done_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
`ifdef UART_CONSOLE_IRQ_EN
  logic        int_q, int_d, irq_pend_q, irq_pend_d;
`endif

  logic aw_ok, w_ok, rx_elig, tx_elig, idle_go, tx_ready;
  logic unused_ok;

  assign unused_ok = ^{m_axilite_rdata[31:8], int_i};
  assign tx_ready  = init_done_q && !tx_full_q;

  always_comb begin
    state_d        = state_q;
    awaddr_d       = awaddr_q;
    awvalid_d      = awvalid_q;
    wdata_d        = wdata_q;
    wvalid_d       = wvalid_q;
    bready_d       = bready_q;
    araddr_d       = araddr_q;
    arvalid_d      = arvalid_q;
    rready_d       = rready_q;
    req_sent_d     = req_sent_q;
    tx_full_d      = tx_full_q;
    tx_byte_d      = tx_byte_q;
    rx_full_d      = rx_full_q;
    rx_data_d      = rx_data_q;
    err_d          = err_q;
    rx_avail_d     = rx_avail_q;
    tx_fifo_full_d = tx_fifo_full_q;
    last_rx_d      = last_rx_q;
    init_done_d    = init_done_q;
    poll_cnt_d     = poll_cnt_q;
    rx_elig        = 1'b0;
    tx_elig        = 1'b0;
    aw_ok          = !awvalid_q || m_axilite_awready;
    w_ok           = !wvalid_q || m_axilite_wready;
`ifdef UART_CONSOLE_IRQ_EN
    int_d      = int_i;
    irq_pend_d = irq_pend_q;
    // Poll at once on interrupt or a fresh TX byte; a full UART FIFO is retried on the interval.
    idle_go    = irq_pend_q || (tx_full_q && (!tx_fifo_full_q || poll_cnt_q == POLL_LAST));
`else
    idle_go    = (poll_cnt_q == POLL_LAST);
`endif

    if (tx_valid_i && tx_ready) begin
      tx_full_d = 1'b1;
      tx_byte_d = tx_data_i;
    end
    if (rx_full_q && rx_ready_i) rx_full_d = 1'b0;

    case (state_q)
      ST_INIT, ST_TX_AW: begin
        if (!req_sent_q) begin
          req_sent_d = 1'b1;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          awaddr_d   = BASE_ADDR + ((state_q == ST_INIT) ? CTRL_OFF : TX_OFF);
          wdata_d    = (state_q == ST_INIT) ? CTRL_INIT : {24'h0, tx_byte_q};
        end else begin
          if (m_axilite_awready) awvalid_d = 1'b0;
          if (m_axilite_wready)  wvalid_d  = 1'b0;
          if (aw_ok && w_ok) begin
            req_sent_d = 1'b0;
            bready_d   = 1'b1;
            state_d    = (state_q == ST_INIT) ? ST_INIT_B : ST_TX_B;
          end
        end
      end
      ST_INIT_B, ST_TX_B: begin
        if (m_axilite_bvalid && bready_q) begin
          bready_d = 1'b0;
          if (m_axilite_bresp != 2'b00) err_d = 1'b1;
          if (state_q == ST_INIT_B) begin
            init_done_d = 1'b1;
            poll_cnt_d  = 16'd0;
            state_d     = ST_IDLE;
          end else begin
            tx_full_d = 1'b0;
            state_d   = ST_STAT_AR;
          end
        end
      end
      ST_IDLE: begin
        poll_cnt_d = (poll_cnt_q == POLL_LAST) ? 16'd0 : poll_cnt_q + 16'd1;
        if (idle_go) state_d = ST_STAT_AR;
      end
      ST_STAT_AR, ST_RX_AR: begin
        if (!req_sent_q) begin
          req_sent_d = 1'b1;
          arvalid_d  = 1'b1;
          araddr_d   = BASE_ADDR + ((state_q == ST_STAT_AR) ? STAT_OFF : RX_OFF);
        end else if (m_axilite_arready) begin
          req_sent_d = 1'b0;
          arvalid_d  = 1'b0;
          rready_d   = 1'b1;
          state_d    = (state_q == ST_STAT_AR) ? ST_STAT_R : ST_RX_R;
        end
      end
      ST_STAT_R: begin
        if (m_axilite_rvalid && rready_q) begin
          rready_d       = 1'b0;
          if (m_axilite_rresp != 2'b00) err_d = 1'b1;
          rx_avail_d     = m_axilite_rdata[0];
          tx_fifo_full_d = m_axilite_rdata[3];
          rx_elig        = m_axilite_rdata[0] && !rx_full_q;
          tx_elig        = tx_full_q && !m_axilite_rdata[3];
          // last_rx hands the next turn to TX so neither direction starves the other.
          if (rx_elig && !(tx_elig && last_rx_q)) begin
            last_rx_d = 1'b1;
            state_d   = ST_RX_AR;
          end else if (tx_elig) begin
            last_rx_d = 1'b0;
            state_d   = ST_TX_AW;
          end else begin
            poll_cnt_d = 16'd0;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_RX_R: begin
        if (m_axilite_rvalid && rready_q) begin
          rready_d  = 1'b0;
          if (m_axilite_rresp != 2'b00) err_d = 1'b1;
          rx_data_d = m_axilite_rdata[7:0];
          rx_full_d = 1'b1;
          state_d   = ST_STAT_AR;
        end
      end
      default: state_d = ST_INIT;
    endcase

`ifdef UART_CONSOLE_IRQ_EN
    if (state_d == ST_STAT_AR && state_q != ST_STAT_AR) irq_pend_d = 1'b0;
    if (int_i && !int_q) irq_pend_d = 1'b1;
`endif
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q        <= ST_INIT;
      awaddr_q       <= 32'h0;
      awvalid_q      <= 1'b0;
      wdata_q        <= 32'h0;
      wvalid_q       <= 1'b0;
      bready_q       <= 1'b0;
      araddr_q       <= 32'h0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
      req_sent_q     <= 1'b0;
      tx_full_q      <= 1'b0;
      tx_byte_q      <= 8'h0;
      rx_full_q      <= 1'b0;
      rx_data_q      <= 8'h0;
      err_q          <= 1'b0;
      rx_avail_q     <= 1'b0;
      tx_fifo_full_q <= 1'b0;
      last_rx_q      <= 1'b0;
      init_done_q    <= 1'b0;
      poll_cnt_q     <= 16'd0;
`ifdef UART_CONSOLE_IRQ_EN
      int_q          <= 1'b0;
      irq_pend_q     <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      awaddr_q       <= awaddr_d;
      awvalid_q      <= awvalid_d;
      wdata_q        <= wdata_d;
      wvalid_q       <= wvalid_d;
      bready_q       <= bready_d;
      araddr_q       <= araddr_d;
      arvalid_q      <= arvalid_d;
      rready_q       <= rready_d;
      req_sent_q     <= req_sent_d;
      tx_full_q      <= tx_full_d;
      tx_byte_q      <= tx_byte_d;
      rx_full_q      <= rx_full_d;
      rx_data_q      <= rx_data_d;
      err_q          <= err_d;
      rx_avail_q     <= rx_avail_d;
      tx_fifo_full_q <= tx_fifo_full_d;
      last_rx_q      <= last_rx_d;
      init_done_q    <= init_done_d;
      poll_cnt_q     <= poll_cnt_d;
`ifdef UART_CONSOLE_IRQ_EN
      int_q          <= int_d;
      irq_pend_q     <= irq_pend_d;
`endif
    end
  end

  assign m_axilite_awaddr  = awaddr_q;
  assign m_axilite_awprot  = 3'b000;
  assign m_axilite_awvalid = awvalid_q;
  assign m_axilite_wdata   = wdata_q;
  assign m_axilite_wstrb   = 4'hF;
  assign m_axilite_wvalid  = wvalid_q;
  assign m_axilite_bready  = bready_q;
  assign m_axilite_araddr  = araddr_q;
  assign m_axilite_arprot  = 3'b000;
  assign m_axilite_arvalid = arvalid_q;
  assign m_axilite_rready  = rready_q;
  assign tx_ready_o        = tx_ready;
  assign rx_data_o         = rx_data_q;
  assign rx_valid_o        = rx_full_q;
  assign err_o             = err_q;
  assign dbg_o             = {last_rx_q, tx_fifo_full_q, rx_avail_q, init_done_q, state_q};

endmodule

// File: tb/tb_axilite_uart_console_master.sv
// Bench for axilite_uart_console_master: randomised-ready UART Lite slave model plus
// scoreboards for bus writes and delivered RX bytes.
module tb_axilite_uart_console_master;
  localparam logic [31:0] BASE = 32'h4060_0000;
  localparam int          POLL = 8;
`ifdef UART_CONSOLE_IRQ_EN
  localparam logic [31:0] CTRL_EXP = 32'h13;
`else
  localparam logic [31:0] CTRL_EXP = 32'h03;
`endif

  logic        clk, rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;
  logic [7:0]  tx_data_i, rx_data_o, dbg_o;
  logic        tx_valid_i, tx_ready_o, rx_valid_o, rx_ready_i, int_i, err_o;

  int          n_cmp, n_err;
  logic [63:0] exp_q[$];
  logic [7:0]  exp_rx_q[$];
  logic [7:0]  slave_rx_q[$];
  logic [7:0]  trace_q[$];
  logic [7:0]  stat_val;
  logic [1:0]  bresp_val;
  logic        stall_ar;
  int          n_stat, n_rxrd, n_txwr;

  axilite_uart_console_master #(.BASE_ADDR(BASE), .POLL_INTERVAL(POLL)) dut (
    .clock_i(clk), .reset_ni(rst_n),
    .m_axilite_awaddr(awaddr), .m_axilite_awprot(awprot), .m_axilite_awvalid(awvalid),
    .m_axilite_awready(awready),
    .m_axilite_wdata(wdata), .m_axilite_wstrb(wstrb), .m_axilite_wvalid(wvalid),
    .m_axilite_wready(wready),
    .m_axilite_bresp(bresp), .m_axilite_bvalid(bvalid), .m_axilite_bready(bready),
    .m_axilite_araddr(araddr), .m_axilite_arprot(arprot), .m_axilite_arvalid(arvalid),
    .m_axilite_arready(arready),
    .m_axilite_rdata(rdata), .m_axilite_rresp(rresp), .m_axilite_rvalid(rvalid),
    .m_axilite_rready(rready),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .int_i(int_i), .err_o(err_o), .dbg_o(dbg_o)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    while (!tx_ready_o && t < 500) begin
      step();
      t++;
    end
    check("send_ready", tx_ready_o, 1);
    tx_data_i  = b;
    tx_valid_i = 1'b1;
    step();
    tx_valid_i = 1'b0;
    exp_q.push_back({BASE + 32'h4, 24'h0, b});
    check("tx_ready_low", tx_ready_o, 0);
  endtask

  task automatic wait_tx_done(input string tag);
    int t = 0;
    while (!(exp_q.size() == 0 && tx_ready_o) && t < 2000) begin
      step();
      t++;
    end
    check(tag, {exp_q.size() == 0, tx_ready_o}, 2'b11);
  endtask

  task automatic push_rx(input logic [7:0] b);
    slave_rx_q.push_back(b);
    exp_rx_q.push_back(b);
  endtask

  task automatic pulse_int();
    int_i = 1'b1;
    step();
    int_i = 1'b0;
  endtask

  task automatic wait_rx_drained(input string tag);
    int t = 0;
    while (exp_rx_q.size() != 0 && t < 2000) begin
      step();
      t++;
    end
    check(tag, exp_rx_q.size(), 0);
  endtask

  // UART Lite slave model: readies randomised, one response per accepted request
  initial begin : slave
    logic        aw_got, w_got, ar_got, b_fire, r_fire;
    logic [31:0] aw_a, w_d, ar_a;
    aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
    aw_a = 0; w_d = 0; ar_a = 0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; bresp = 0; rvalid = 0; rdata = 0; rresp = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      end else begin
        if (b_fire) bvalid = 1'b0;
        if (r_fire) rvalid = 1'b0;
        if (aw_got && w_got) begin
          check("wr_pending", exp_q.size() > 0, 1);
          check("wr_tx_ready_low", tx_ready_o, 0);
          if (exp_q.size() > 0) check("wr_txn", {aw_a, w_d}, exp_q.pop_front());
          if (aw_a == BASE + 32'h4) begin
            n_txwr++;
            trace_q.push_back(8'h54);
          end
          bvalid = 1'b1;
          bresp  = bresp_val;
          aw_got = 0;
          w_got  = 0;
        end
        if (ar_got) begin
          if (ar_a == BASE + 32'h8) begin
            n_stat++;
            rdata = {24'h0, stat_val[7:1], slave_rx_q.size() != 0};
          end else begin
            check("araddr_rx", ar_a, BASE);
            n_rxrd++;
            trace_q.push_back(8'h52);
            rdata = (slave_rx_q.size() != 0) ? {24'h0, slave_rx_q.pop_front()} : 32'hEE;
          end
          rvalid = 1'b1;
          rresp  = 2'b00;
          ar_got = 0;
        end
        awready = !aw_got && !bvalid && ($urandom_range(0, 3) != 0);
        wready  = !w_got && !bvalid && ($urandom_range(0, 3) != 0);
        arready = !ar_got && !rvalid && !stall_ar && ($urandom_range(0, 3) != 0);
        if (awvalid && awready) begin
          aw_got = 1;
          aw_a   = awaddr;
          check("awprot", awprot, 0);
        end
        if (wvalid && wready) begin
          w_got = 1;
          w_d   = wdata;
          check("wstrb", wstrb, 4'hF);
        end
        if (arvalid && arready) begin
          ar_got = 1;
          ar_a   = araddr;
          check("arprot", arprot, 0);
        end
        b_fire = bvalid && bready;
        r_fire = rvalid && rready;
      end
    end
  end

  // scoreboard for bytes handed to the RX consumer
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rx_valid_o && rx_ready_i) begin
        check("rx_pending", exp_rx_q.size() > 0, 1);
        if (exp_rx_q.size() > 0) check("rx_byte", rx_data_o, exp_rx_q.pop_front());
      end
    end
  end

  initial begin
    int          s0, w0, r0, t;
    logic        found;
    logic [23:0] seq;
    n_cmp = 0; n_err = 0; n_stat = 0; n_rxrd = 0; n_txwr = 0;
    rst_n = 1'b0; tx_valid_i = 0; tx_data_i = 0; rx_ready_i = 0; int_i = 0;
    stat_val = 8'h00; bresp_val = 2'b00; stall_ar = 0;
    step(3);

    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_awaddr", awaddr, 0);
    check("rst_araddr", araddr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_tx_ready", tx_ready_o, 0);
    check("rst_rx_valid", rx_valid_o, 0);
    check("rst_rx_data", rx_data_o, 0);
    check("rst_err", err_o, 0);
    check("rst_state", dbg_o[3:0], 0);

    // init write of CTRL, then TX becomes ready
    exp_q.push_back({BASE + 32'hC, CTRL_EXP});
    rst_n = 1'b1;
    wait_tx_done("init_done");

    // single TX byte, then a few random ones
    stat_val = 8'h04;
    send_byte(8'h41);
    wait_tx_done("tx_41_done");
    for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 255)));
    wait_tx_done("tx_rand_done");

    // UART TX FIFO full: only STAT polls until it drains
    stat_val = 8'h08;
    s0 = n_stat;
    w0 = n_txwr;
    send_byte(8'h44);
    step(60);
    check("full_no_write", n_txwr - w0, 0);
    check("full_polled", n_stat - s0 > 2, 1);
    stat_val = 8'h04;
    wait_tx_done("full_release");

    // contention: RX and TX eligible together alternate R, T, R
    stat_val = 8'h08;
    send_byte(8'h42);
    step(10);
    rx_ready_i = 1'b1;
    trace_q.delete();
    push_rx(8'h11);
    push_rx(8'h22);
    stat_val = 8'h00;
    pulse_int();
    t = 0;
    while (trace_q.size() < 3 && t < 2000) begin
      step();
      t++;
    end
    seq = 24'h0;
    for (int i = 0; i < 3 && i < trace_q.size(); i++) seq[23 - 8 * i -: 8] = trace_q[i];
    check("contention_order", seq, 24'h52_54_52);
    wait_tx_done("contention_tx_done");
    wait_rx_drained("contention_rx_drained");

    // RX held by consumer: exactly one RX read while holding register is full
    rx_ready_i = 1'b0;
    r0 = n_rxrd;
    push_rx(8'h5A);
    push_rx(8'h5B);
    pulse_int();
    t = 0;
    while (!rx_valid_o && t < 2000) begin
      step();
      t++;
    end
    check("rx_valid_rise", rx_valid_o, 1);
    check("rx_data_5a", rx_data_o, 8'h5A);
    step(20);
    check("rx_hold_reads", n_rxrd - r0, 1);
    check("rx_still_valid", rx_valid_o, 1);
    rx_ready_i = 1'b1;
    pulse_int();
    wait_rx_drained("rx_drained");

    // error response on TX write: sticky err, FSM re-polls STAT at once
    stat_val  = 8'h04;
    bresp_val = 2'b10;
    send_byte(8'h45);
    wait_tx_done("err_tx_done");
    check("err_set", err_o, 1);
    bresp_val = 2'b00;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (arvalid && araddr == BASE + 32'h8) found = 1'b1;
      step();
    end
    check("err_restat", found, 1);
    send_byte(8'h46);
    wait_tx_done("err_next_tx");
    check("err_sticky", err_o, 1);

    // asynchronous reset in the middle of a stalled AR
    stall_ar = 1'b1;
    t = 0;
    while (!arvalid && t < 200) begin
      step();
      t++;
    end
    check("ar_stalled", arvalid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_arvalid", arvalid, 0);
    check("arst_err", err_o, 0);
    check("arst_tx_ready", tx_ready_o, 0);
    step(2);
    stall_ar = 1'b0;
    exp_q.push_back({BASE + 32'hC, CTRL_EXP});
    rst_n = 1'b1;
    wait_tx_done("reinit_done");
    check("reinit_err", err_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axilite_uart_console_master.md
# axilite_uart_console_master

AXI4-Lite initiator that drives a UART Lite–compatible register map (the `xlnx_axi_uartlite` slave or `virtual_uart`), so that on-chip logic can exchange bytes through simple valid/ready streams. It sits upstream of the UART's AXI-Lite slave port, either directly or through the crossbar. Typical users are a boot loader, a debug monitor or a test sequencer. It initialises the UART, reads status, drains the RX FIFO into a byte stream and pushes a byte stream into the TX FIFO.

## Interface
- `BASE_ADDR`, `32'h0000_0000`: UART base address; registers are at +0x0 RX, +0x4 TX, +0x8 STAT, +0xC CTRL.
- `POLL_INTERVAL`, `16`: number of idle cycles between status polls (1..65535).
- `clock_i` in, 1: single clock.
- `reset_ni` in, 1: reset, asynchronous, active-low.
- `m_axilite_aw{addr[31:0],prot[2:0],valid}` out, `awready` in: write address channel.
- `m_axilite_w{data[31:0],strb[3:0],valid}` out, `wready` in: write data channel.
- `m_axilite_b{resp[1:0],valid}` in, `bready` out: write response channel.
- `m_axilite_ar{addr[31:0],prot[2:0],valid}` out, `arready` in: read address channel.
- `m_axilite_r{data[31:0],resp[1:0],valid}` in, `rready` out: read data channel.
- `tx_data_i` in, 8: byte to transmit.
- `tx_valid_i` in, 1: TX byte valid.
- `tx_ready_o` out, 1: TX holding register empty.
- `rx_data_o` out, 8: received byte.
- `rx_valid_o` out, 1: RX byte valid.
- `rx_ready_i` in, 1: consumer accepts the RX byte.
- `int_i` in, 1: UART interrupt (`int_core_o` of the UART).
- `err_o` out, 1: sticky; set on any non-OKAY BRESP/RRESP.

## Operation
- Exactly one AXI transaction is outstanding at a time. `prot` is always 3'b000. `strb` is always 4'hF.
- Holding registers:
  - One-entry TX holding register. `tx_ready_o` = !tx_full. Capture on `tx_valid_i && tx_ready_o`.
  - One-entry RX holding register. `rx_valid_o` = rx_full. It clears on `rx_valid_o && rx_ready_i`.
  - Capture and release are independent of the FSM.
- FSM states:
  - **INIT**: write CTRL = 0x13 with `UART_CONSOLE_IRQ_EN`, 0x03 without (reset both FIFOs). Next state is INIT_B.
  - **INIT_B**: wait for B, then go to IDLE.
  - **IDLE**: wait for a poll trigger (see Configuration), then go to STAT_AR.
  - **STAT_AR / STAT_R**: read STAT. Latch `rx_avail` = bit0 and `tx_fifo_full` = bit3.
  - **Decision**, taken on the STAT R handshake:
    - `rx_avail` and RX holding empty → RX_AR.
    - Else TX holding full and !`tx_fifo_full` → TX_AW.
    - Else → IDLE.
    - When both RX and TX are eligible, they alternate; a `last_rx` flag gives TX priority after an RX service.
  - **RX_AR / RX_R**: read RX. On the R handshake, `rx_data_o` ← `rdata[7:0]`, rx_full ← 1. Next is STAT_AR (re-poll immediately).
  - **TX_AW / TX_B**: write TX with `wdata` = {24'h0, byte}. On the B handshake, tx_full ← 0. Next is STAT_AR.
- On a non-OKAY response, `err_o` ← 1 and the FSM proceeds as if the response were OKAY. For an RX read with an error, the data is still delivered.
- Address arithmetic: `BASE_ADDR` + offset, 32-bit, wrap-around ignored.

## Timing
- Reset values: all `valid`/`ready` outputs are 0, `awaddr`/`araddr`/`wdata` are 0, `tx_ready_o`=0 while in INIT/INIT_B, `rx_valid_o`=0, `rx_data_o`=0, `err_o`=0. The FSM starts in INIT.
- AW and W are raised in the same cycle. Each drops on its own handshake. B is awaited only after both handshakes. `bready` is 1 only in the B-wait states.
- `arvalid` holds until `arready`. `rready` is 1 only in the R-wait states.
- Outputs are registered. Address and valid are asserted on the cycle after state entry.
- Zero-wait slave: a STAT poll is at minimum 4 cycles from trigger to decision.
- `tx_ready_o` is 1 from the first IDLE entry after INIT, and again from the cycle after the TX B handshake.
- `rx_valid_o` rises the cycle after the RX R handshake.
- A simultaneous `rx_ready_i` release and a new RX capture cannot occur: RX is read only when the holding register is empty.
- An asynchronous reset mid-transaction abandons it immediately. Slave-side recovery is outside this block (a shared reset is required).

## Configuration
- `UART_CONSOLE_IRQ_EN` defined:
  - A rising edge of `int_i` sets `irq_pend`, which is cleared on STAT AR entry.
  - IDLE exits on `irq_pend` or TX holding full, or when the POLL_INTERVAL counter expires with TX holding full (retry if the FIFO was full).
  - INIT writes CTRL=0x13.
- Undefined:
  - `int_i` is ignored.
  - IDLE exits when a counter reaches POLL_INTERVAL. The counter resets on IDLE entry.
  - INIT writes CTRL=0x03.

## Test plan
- **Reset then idle slave model:** the first transaction is AW=BASE+0xC with W=0x03 (0x13 with IRQ_EN); `tx_ready_o` rises after B.
- **TX path:** push byte 0x41 with STAT=0x04 → write of 0x00000041 to BASE+0x4; `tx_ready_o` low until B, then high.
- **RX path:** STAT=0x01, RX data 0x5A → `rx_valid_o`=1 and `rx_data_o`=0x5A; hold `rx_ready_i`=0 for 20 cycles → no further RX reads.
- **Contention:** STAT=0x01 persistent with TX pending → transactions alternate RX read, TX write, RX read.
- **TX FIFO full:** STAT=0x08 with TX pending → only STAT reads, no TX write, until STAT=0x04.
- **Error:** BRESP=2'b10 on a TX write → `err_o`=1 and stays 1; the FSM returns to STAT_AR; a reset mid-AR clears `arvalid` and `err_o` asynchronously.
